// File: rtl/apb_mstr_bridge.sv
// rtl/apb_mstr_bridge.sv - single-outstanding APB requester with a wait-state watchdog
module apb_mstr_bridge #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                    PCLK,
   input  logic                    PRESET,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_strb,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err,
   output logic                    rsp_timeout,
   output logic                    PSELx,
   output logic                    PENABLE,
   output logic                    PWRITE,
   output logic [ADDR_WIDTH-1:0]   PADDR,
   output logic [DATA_WIDTH-1:0]   PWDATA,
   output logic [DATA_WIDTH/8-1:0] PSTRB,
   input  logic [DATA_WIDTH-1:0]   PRDATA,
   input  logic                    PREADY,
   input  logic                    PSLVERR
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [1:0] ST_RESP   = 2'd3;

   // Counter keeps at least one bit so the watchdog-disabled build still elaborates.
   localparam bit          WDOG_EN   = (TIMEOUT_CYCLES != 0);
   localparam int          CW        = WDOG_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int          LAST_I    = WDOG_EN ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [CW-1:0] WAIT_LAST = CW'(LAST_I);

   logic [1:0]              state_q,     state_d;
   logic                    cmd_ready_q, cmd_ready_d;
   logic                    psel_q,      psel_d;
   logic                    penable_q,   penable_d;
   logic                    pwrite_q,    pwrite_d;
   logic [ADDR_WIDTH-1:0]   paddr_q,     paddr_d;
   logic [DATA_WIDTH-1:0]   pwdata_q,    pwdata_d;
   logic [DATA_WIDTH/8-1:0] pstrb_q,     pstrb_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                    rsp_err_q,   rsp_err_d;
   logic                    rsp_to_q,    rsp_to_d;
   logic [CW-1:0]           wait_q,      wait_d;

   always_comb begin
      state_d     = state_q;
      cmd_ready_d = cmd_ready_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      pstrb_d     = pstrb_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      rsp_to_d    = rsp_to_q;
      wait_d      = wait_q;
      case (state_q)
         ST_IDLE: begin
            cmd_ready_d = 1'b1;
            if (cmd_valid && cmd_ready_q) begin
               cmd_ready_d = 1'b0;
               psel_d      = 1'b1;
               pwrite_d    = cmd_write;
               paddr_d     = cmd_addr;
               pwdata_d    = cmd_wdata;
               pstrb_d     = cmd_write ? cmd_strb : '0;
               state_d     = ST_SETUP;
            end
         end
         ST_SETUP: begin
            penable_d = 1'b1;
            state_d   = ST_ACCESS;
         end
         ST_ACCESS: begin
            // A slave completing on the last allowed cycle wins over the watchdog.
            if (PREADY) begin
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = pwrite_q ? '0 : PRDATA;
               rsp_err_d   = PSLVERR;
               rsp_to_d    = 1'b0;
               wait_d      = '0;
               state_d     = ST_RESP;
            end else if (WDOG_EN && (wait_q == WAIT_LAST)) begin
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b1;
               rsp_to_d    = 1'b1;
               wait_d      = '0;
               state_d     = ST_RESP;
            end else begin
               wait_d = wait_q + CW'(1);
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q     <= ST_IDLE;
         cmd_ready_q <= 1'b0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         pstrb_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         rsp_to_q    <= 1'b0;
         wait_q      <= '0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         pstrb_q     <= pstrb_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         rsp_to_q    <= rsp_to_d;
         wait_q      <= wait_d;
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_to_q;
   assign PSELx       = psel_q;
   assign PENABLE     = penable_q;
   assign PWRITE      = pwrite_q;
   assign PADDR       = paddr_q;
   assign PWDATA      = pwdata_q;
   assign PSTRB       = pstrb_q;

endmodule

// File: tb/tb_apb_mstr_bridge.sv
// tb/tb_apb_mstr_bridge.sv - directed vector bench for apb_mstr_bridge
module tb_apb_mstr_bridge;

   logic        PCLK = 1'b0;
   logic        PRESET;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_strb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        rsp_timeout;
   logic        PSELx;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic [3:0]  PSTRB;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   int tests = 0;
   int fails = 0;

   apb_mstr_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
      .PSLVERR(PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          waits;
      logic        slverr;
      logic [31:0] prdata;
      int          hold;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic        exp_to;
      logic [3:0]  exp_pstrb;
      int          exp_pen;
   } vec_t;

   vec_t vt[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   // Runs one command end to end, acting as the APB slave; starts and ends in IDLE.
   task automatic run_vec(input int i, input vec_t v);
      int pen;
      check($sformatf("v%0d_cmd_ready_idle", i), {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1;
      cmd_write = v.wr;
      cmd_addr  = v.addr;
      cmd_wdata = v.wdata;
      cmd_strb  = v.strb;
      tick();
      cmd_valid = 1'b0;
      check($sformatf("v%0d_setup_psel", i), {30'd0, PSELx, PENABLE}, 32'd2);
      check($sformatf("v%0d_setup_addr", i), PADDR, v.addr);
      check($sformatf("v%0d_setup_pstrb", i), {28'd0, PSTRB}, {28'd0, v.exp_pstrb});
      check($sformatf("v%0d_cmd_ready_busy", i), {31'd0, cmd_ready}, 32'd0);
      tick();
      check($sformatf("v%0d_access_penable", i), {30'd0, PSELx, PENABLE}, 32'd3);
      pen = 0;
      while (PENABLE === 1'b1 && pen < 40) begin
         pen++;
         check($sformatf("v%0d_access_stable", i), PADDR ^ PWDATA ^ {27'd0, PWRITE, PSTRB},
               v.addr ^ v.wdata ^ {27'd0, v.wr, v.exp_pstrb});
         PREADY  = (pen > v.waits);
         PSLVERR = PREADY ? v.slverr : 1'b1;
         PRDATA  = PREADY ? v.prdata : 32'hFFFF_0000;
         tick();
      end
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      check($sformatf("v%0d_penable_cycles", i), pen, v.exp_pen);
      check($sformatf("v%0d_resp_bus_idle", i), {30'd0, PSELx, PENABLE}, 32'd0);
      check($sformatf("v%0d_rsp_valid", i), {31'd0, rsp_valid}, 32'd1);
      check($sformatf("v%0d_rsp_rdata", i), rsp_rdata, v.exp_rdata);
      check($sformatf("v%0d_rsp_err_to", i), {30'd0, rsp_err, rsp_timeout},
            {30'd0, v.exp_err, v.exp_to});
      check($sformatf("v%0d_resp_addr_held", i), PADDR, v.addr);
      for (int h = 0; h < v.hold; h++) begin
         cmd_valid = 1'b1;
         cmd_write = ~v.wr;
         cmd_addr  = 32'h0000_0F00;
         tick();
         check($sformatf("v%0d_hold%0d_valid", i, h), {30'd0, rsp_valid, cmd_ready}, 32'd2);
         check($sformatf("v%0d_hold%0d_rdata", i, h), rsp_rdata, v.exp_rdata);
         check($sformatf("v%0d_hold%0d_err_to", i, h), {30'd0, rsp_err, rsp_timeout},
               {30'd0, v.exp_err, v.exp_to});
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check($sformatf("v%0d_rsp_done", i), {30'd0, rsp_valid, cmd_ready}, 32'd1);
      check($sformatf("v%0d_idle_bus", i), {30'd0, PSELx, PENABLE}, 32'd0);
   endtask

   initial begin
      //          wr    addr          wdata          strb   wt   serr  prdata         hold exp_rdata      err   to    pstrb  pen
      vt[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF,    0, 1'b0, 32'hAAAA_5555, 0, 32'h0000_0000, 1'b0, 1'b0, 4'hF,  1};
      vt[1] = '{1'b0, 32'h0000_0020, 32'h0101_0101, 4'hF,    3, 1'b0, 32'h1234_5678, 0, 32'h1234_5678, 1'b0, 1'b0, 4'h0,  4};
      vt[2] = '{1'b1, 32'h0000_0030, 32'hCAFE_F00D, 4'h3,    0, 1'b1, 32'h7777_7777, 0, 32'h0000_0000, 1'b1, 1'b0, 4'h3,  1};
      vt[3] = '{1'b0, 32'h0000_0040, 32'h0000_0000, 4'hF, 1000, 1'b0, 32'h9999_9999, 0, 32'h0000_0000, 1'b1, 1'b1, 4'h0, 16};
      vt[4] = '{1'b0, 32'h0000_0044, 32'h0000_0000, 4'h0,   15, 1'b0, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 1'b0, 1'b0, 4'h0, 16};
      vt[5] = '{1'b1, 32'h0000_0050, 32'h1122_3344, 4'h5,    1, 1'b0, 32'h5555_5555, 5, 32'h0000_0000, 1'b0, 1'b0, 4'h5,  2};
      vt[6] = '{1'b0, 32'h0000_0060, 32'hFFFF_FFFF, 4'hA,    0, 1'b1, 32'h55AA_55AA, 2, 32'h55AA_55AA, 1'b1, 1'b0, 4'h0,  1};

      PRESET    = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      cmd_strb  = '0;
      rsp_ready = 1'b0;
      PRDATA    = '0;
      PREADY    = 1'b0;
      PSLVERR   = 1'b0;
      repeat (3) tick();
      check("reset_ctrl", {26'd0, cmd_ready, rsp_valid, rsp_err, rsp_timeout, PSELx, PENABLE}, 32'd0);
      check("reset_bus", PADDR | PWDATA | {27'd0, PWRITE, PSTRB} | rsp_rdata, 32'd0);
      PRESET = 1'b0;
      tick();
      check("post_reset_ready", {31'd0, cmd_ready}, 32'd1);

      for (int i = 0; i < 7; i++) run_vec(i, vt[i]);

      // Reset while the slave is stalling in ACCESS.
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 32'h0000_0070;
      cmd_wdata = 32'h7070_7070;
      cmd_strb  = 4'hF;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      check("midrst_in_access", {30'd0, PSELx, PENABLE}, 32'd3);
      PRESET = 1'b1;
      tick();
      check("midrst_ctrl", {26'd0, cmd_ready, rsp_valid, rsp_err, rsp_timeout, PSELx, PENABLE}, 32'd0);
      check("midrst_bus", PADDR | PWDATA | {27'd0, PWRITE, PSTRB}, 32'd0);
      PRESET = 1'b0;
      rsp_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("midrst_no_rsp%0d", k), {30'd0, rsp_valid, PSELx}, 32'd0);
      end
      rsp_ready = 1'b0;
      run_vec(7, vt[0]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
